mem_arbiter: RTL and testbench

- Sequences the shared memory_controller and shares it between three requesters: front-panel loader (ld), execute unit (ex), instruction fetch (if).
- Issues one-cycle read/write strobes with the correct read_type, waits the memory read latency and returns data with a one-cycle done pulse.
- Implements an atomic read-increment-write operation for ISZ and autoindex (0010-0017) accesses.
- Sits between the CPU front end / execute FSM and memory_controller; all addresses and data are 12-bit `word`.

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way arbiter and sequencer for the shared memory_controller: loader, execute
// unit and instruction fetch, with an atomic read-increment-write for the execute unit.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [11:0] ld_addr,
  input  logic [11:0] ld_wdata,
  output logic        ld_done,
  input  logic        ex_req,
  input  logic [1:0]  ex_op,
  input  logic [11:0] ex_addr,
  input  logic [11:0] ex_wdata,
  output logic        ex_done,
  output logic        ex_zero,
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_done,
  output logic [11:0] rdata,
  output logic        busy,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  input  logic [11:0] mem_read_data
);

  localparam logic DATA_READ         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;
  localparam int   WAIT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int   STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RMW} op_t;
  typedef enum logic [1:0] {ID_LD, ID_EX, ID_IF} id_t;

  state_t              state_reg;
  op_t                 op_reg;
  id_t                 id_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [STARVE_W-1:0] starve_reg;
  logic [2:0]          done_reg;
  logic                ex_zero_reg;
  logic [11:0]         rdata_reg;
  logic                busy_reg;
  logic [11:0]         mem_address_reg;
  logic [11:0]         mem_write_data_reg;
  logic                mem_read_enable_reg;
  logic                mem_read_type_reg;
  logic                mem_write_enable_reg;

  logic        grant_valid;
  id_t         grant_id;
  op_t         grant_op;
  op_t         ex_op_dec;
  logic [11:0] grant_addr;
  logic [11:0] grant_wdata;
  logic        starve_max;

  assign starve_max = (starve_reg == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    case (ex_op)
      2'b01:   ex_op_dec = OP_WRITE;
      2'b10:   ex_op_dec = OP_RMW;
      default: ex_op_dec = OP_READ;
    endcase
  end

  // Fixed priority ld > ex > if, except a starved fetch overtakes ex.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_LD;
    grant_op    = OP_READ;
    grant_addr  = 12'd0;
    grant_wdata = 12'd0;
    if (ld_req) begin
      grant_valid = 1'b1;
      grant_id    = ID_LD;
      grant_op    = ld_we ? OP_WRITE : OP_READ;
      grant_addr  = ld_addr;
      grant_wdata = ld_wdata;
    end else if (ex_req && !(if_req && starve_max)) begin
      grant_valid = 1'b1;
      grant_id    = ID_EX;
      grant_op    = ex_op_dec;
      grant_addr  = ex_addr;
      grant_wdata = ex_wdata;
    end else if (if_req) begin
      grant_valid = 1'b1;
      grant_id    = ID_IF;
      grant_op    = OP_READ;
      grant_addr  = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      op_reg               <= OP_READ;
      id_reg               <= ID_LD;
      wait_cnt_reg         <= '0;
      starve_reg           <= '0;
      done_reg             <= 3'b000;
      ex_zero_reg          <= 1'b0;
      rdata_reg            <= 12'd0;
      busy_reg             <= 1'b0;
      mem_address_reg      <= 12'd0;
      mem_write_data_reg   <= 12'd0;
      mem_read_enable_reg  <= 1'b0;
      mem_read_type_reg    <= DATA_READ;
      mem_write_enable_reg <= 1'b0;
    end else begin
      done_reg             <= 3'b000;
      ex_zero_reg          <= 1'b0;
      mem_read_enable_reg  <= 1'b0;
      mem_write_enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid && grant_id == ID_EX && if_req) begin
            if (!starve_max) starve_reg <= starve_reg + 1'b1;
          end else if ((grant_valid && grant_id == ID_IF) || !if_req) begin
            starve_reg <= '0;
          end
          if (grant_valid) begin
            id_reg             <= grant_id;
            op_reg             <= grant_op;
            mem_address_reg    <= grant_addr;
            mem_write_data_reg <= grant_wdata;
            mem_read_type_reg  <= (grant_id == ID_IF) ? INSTRUCTION_FETCH : DATA_READ;
            wait_cnt_reg       <= '0;
            busy_reg           <= 1'b1;
            if (grant_op == OP_WRITE) begin
              state_reg            <= WR;
              mem_write_enable_reg <= 1'b1;
            end else begin
              state_reg           <= RD;
              mem_read_enable_reg <= 1'b1;
            end
          end
        end
        RD: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_W'(MEM_LATENCY - 1)) begin
            if (op_reg == OP_RMW) begin
              mem_write_data_reg   <= mem_read_data + 12'd1;
              mem_write_enable_reg <= 1'b1;
              state_reg            <= WR;
            end else begin
              rdata_reg        <= mem_read_data;
              done_reg[id_reg] <= 1'b1;
              state_reg        <= DONE;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        WR: begin
          done_reg[id_reg] <= 1'b1;
          // A plain write leaves rdata untouched; RMW reports the incremented value.
          if (op_reg == OP_RMW) begin
            rdata_reg   <= mem_write_data_reg;
            ex_zero_reg <= (mem_write_data_reg == 12'd0);
          end
          state_reg <= DONE;
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ld_done          = done_reg[0];
  assign ex_done          = done_reg[1];
  assign if_done          = done_reg[2];
  assign ex_zero          = ex_zero_reg;
  assign rdata            = rdata_reg;
  assign busy             = busy_reg;
  assign mem_address      = mem_address_reg;
  assign mem_write_data   = mem_write_data_reg;
  assign mem_read_enable  = mem_read_enable_reg;
  assign mem_read_type    = mem_read_type_reg;
  assign mem_write_enable = mem_write_enable_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory, a reference memory and
// an in-order completion scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [11:0] ld_addr = 12'd0, ld_wdata = 12'd0;
  logic        ld_done;
  logic        ex_req = 1'b0;
  logic [1:0]  ex_op = 2'b00;
  logic [11:0] ex_addr = 12'd0, ex_wdata = 12'd0;
  logic        ex_done, ex_zero;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = 12'd0;
  logic        if_done;
  logic [11:0] rdata;
  logic        busy;
  logic [11:0] mem_address, mem_write_data;
  logic        mem_read_enable, mem_read_type, mem_write_enable;
  logic [11:0] mem_read_data = 12'd0;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
    .ex_req(ex_req), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_done(ex_done), .ex_zero(ex_zero),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_enable(mem_read_enable), .mem_read_type(mem_read_type),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  localparam logic DATA_READ         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] rdata;
    logic        zero;
  } exp_t;

  exp_t        sb_q[$];
  logic [11:0] tb_mem  [0:4095];
  logic [11:0] ref_mem [0:4095];
  logic [11:0] ref_rdata = 12'd0;
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        last_rtype = 1'b0;
  logic [11:0] last_waddr = 12'd0;
  logic [11:0] last_wdata = 12'd0;

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= tb_mem[mem_address];
    if (mem_write_enable) tb_mem[mem_address] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // op: 0=read, 1=write, 2=read-increment-write
  task automatic push_exp(input int who, input int op, input logic [11:0] addr,
                          input logic [11:0] wdata);
    exp_t e;
    logic [11:0] v;
    e.id   = who[1:0];
    e.zero = 1'b0;
    if (op == 1) begin
      ref_mem[addr] = wdata;
    end else if (op == 2) begin
      v = ref_mem[addr] + 12'd1;
      ref_mem[addr] = v;
      ref_rdata = v;
      e.zero = (v == 12'd0);
    end else begin
      ref_rdata = ref_mem[addr];
    end
    e.rdata = ref_rdata;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] id;
    if (mem_read_enable) begin
      rd_cnt++;
      last_rtype = mem_read_type;
    end
    if (mem_write_enable) begin
      wr_cnt++;
      last_waddr = mem_address;
      last_wdata = mem_write_data;
    end
    if (mem_read_enable && mem_write_enable)
      chk("strobe_excl", {mem_read_enable, mem_write_enable}, 2'b00);
    if (ld_done || ex_done || if_done) begin
      chk("done_onehot", $countones({ld_done, ex_done, if_done}), 1);
      id = ld_done ? 2'd0 : (ex_done ? 2'd1 : 2'd2);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {30'd0, id}, 32'hffff_ffff);
      end else begin
        e = sb_q.pop_front();
        $display("txn id=%0d rdata=%04o ex_zero=%0b", id, rdata, ex_zero);
        chk("sb_id", {30'd0, id}, {30'd0, e.id});
        chk("sb_rdata", {20'd0, rdata}, {20'd0, e.rdata});
        chk("sb_zero", {31'd0, ex_zero}, {31'd0, e.zero});
      end
    end
  end

  task automatic do_op(input int who, input int op, input logic [11:0] addr,
                       input logic [11:0] wdata, input int exp_lat, input string tag);
    int k;
    int rd0;
    int wr0;
    logic got;
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    push_exp(who, op, addr, wdata);
    case (who)
      0: begin ld_req = 1'b1; ld_we = (op == 1); ld_addr = addr; ld_wdata = wdata; end
      1: begin ex_req = 1'b1; ex_op = 2'(op); ex_addr = addr; ex_wdata = wdata; end
      default: begin if_req = 1'b1; if_addr = addr; end
    endcase
    k = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if ((who == 0 && ld_done) || (who == 1 && ex_done) || (who == 2 && if_done)) got = 1'b1;
    end
    ld_req = 1'b0;
    ex_req = 1'b0;
    if_req = 1'b0;
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_rd_strobes"}, rd_cnt - rd0, (op == 1) ? 0 : 1);
    chk({tag, "_wr_strobes"}, wr_cnt - wr0, (op == 0) ? 0 : 1);
  endtask

  initial begin
    int k;
    int n_ld;
    int n_ex;
    int n_if;
    int busy_low;
    int wr0;
    for (int i = 0; i < 4096; i++) begin
      tb_mem[i]  = 12'd0;
      ref_mem[i] = 12'd0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, ld_done, ex_done, if_done, ex_zero, mem_read_enable,
                     mem_write_enable, mem_read_type}, 8'h00);
    chk("rst_rdata", rdata, 12'd0);
    chk("rst_addr", mem_address, 12'd0);
    chk("rst_wdata", mem_write_data, 12'd0);
    rst = 1'b0;

    do_op(0, 1, 12'o0200, 12'o0333, 2, "ld_write");
    chk("ld_write_addr", last_waddr, 12'o0200);
    chk("ld_write_data", last_wdata, 12'o0333);
    do_op(0, 0, 12'o0200, 12'd0, 3, "ld_read");
    chk("ld_read_rdata", rdata, 12'o0333);
    chk("ld_read_type", last_rtype, DATA_READ);
    do_op(2, 0, 12'o0200, 12'd0, 3, "if_read");
    chk("if_read_rdata", rdata, 12'o0333);
    chk("if_read_type", last_rtype, INSTRUCTION_FETCH);

    // All three requesters in the same cycle.
    @(negedge clk);
    push_exp(0, 0, 12'o0200, 12'd0);
    push_exp(1, 0, 12'o0200, 12'd0);
    push_exp(2, 0, 12'o0200, 12'd0);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'o0200;
    ex_req = 1'b1; ex_op = 2'b00; ex_addr = 12'o0200;
    if_req = 1'b1; if_addr = 12'o0200;
    k = 0; n_ld = 0; n_ex = 0; n_if = 0; busy_low = 0;
    while ((n_ld + n_ex + n_if) < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (!busy) busy_low++;
      if (ld_done) begin n_ld++; ld_req = 1'b0; end
      if (ex_done) begin n_ex++; ex_req = 1'b0; end
      if (if_done) begin n_if++; if_req = 1'b0; end
    end
    chk("all3_cycles", k, 11);
    chk("all3_busy_low", busy_low, 2);
    chk("all3_counts", {n_ld[7:0], n_ex[7:0], n_if[7:0]}, 24'h010101);

    // Read-increment-write wrapping 7777 -> 0000, then 0000 -> 0001.
    do_op(0, 1, 12'o0010, 12'o7777, 2, "ld_seed");
    do_op(1, 2, 12'o0010, 12'd0, 4, "rmw1");
    chk("rmw1_wdata", last_wdata, 12'o0000);
    chk("rmw1_waddr", last_waddr, 12'o0010);
    chk("rmw1_rdata", rdata, 12'o0000);
    chk("rmw1_zero", ex_zero, 1'b1);
    do_op(1, 2, 12'o0010, 12'd0, 4, "rmw2");
    chk("rmw2_rdata", rdata, 12'o0001);
    chk("rmw2_zero", ex_zero, 1'b0);
    chk("rmw2_mem", tb_mem[12'o0010], 12'o0001);

    // Fetch starvation: ex held with if pending.
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_exp(1, 0, 12'o0200, 12'd0);
    push_exp(2, 0, 12'o0200, 12'd0);
    push_exp(1, 0, 12'o0200, 12'd0);
    ex_req = 1'b1; ex_op = 2'b00; ex_addr = 12'o0200;
    if_req = 1'b1; if_addr = 12'o0200;
    k = 0; n_ex = 0; n_if = 0;
    while ((n_ex < 5 || n_if < 1) && k < 100) begin
      @(negedge clk);
      k++;
      if (ex_done) begin
        n_ex++;
        if (n_ex == 5) ex_req = 1'b0;
      end
      if (if_done) begin
        n_if++;
        chk("starve_if_after_ex", n_ex, 4);
        if_req = 1'b0;
      end
    end
    ex_req = 1'b0;
    if_req = 1'b0;
    chk("starve_counts", {n_ex[7:0], n_if[7:0]}, 16'h0501);

    // Reset during WAIT of a read-increment-write.
    do_op(0, 1, 12'o0020, 12'o0005, 2, "ld_seed2");
    @(negedge clk);
    wr0 = wr_cnt;
    ex_req = 1'b1; ex_op = 2'b10; ex_addr = 12'o0020;
    @(negedge clk);
    chk("abort_rd_strobe", mem_read_enable, 1'b1);
    @(negedge clk);
    chk("abort_busy_wait", busy, 1'b1);
    rst = 1'b1;
    ex_req = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {busy, ld_done, ex_done, if_done, ex_zero, mem_read_enable,
                       mem_write_enable, mem_read_type}, 8'h00);
    chk("abort_rdata", rdata, 12'd0);
    chk("abort_addr", mem_address, 12'd0);
    chk("abort_wdata", mem_write_data, 12'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_write", wr_cnt - wr0, 0);
    chk("abort_mem", tb_mem[12'o0020], 12'o0005);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
